memory_bytelane: RTL and testbench

Second-generation single-port synchronous RAM for the softcore bus. It adds synchronous reset, an optional hardware clear sweep, per-byte write strobes, and selectable 1- or 2-cycle read latency. Every accepted request gets a one-cycle ready pulse. Out-of-range accesses are flagged. It replaces the plain memory cell for instruction/data RAM and still infers block RAM: one write port, registered read.

---
 rtl/memory_bytelane.sv | 144 ++++++++++++++
 tb/tb_memory_bytelane.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_bytelane.sv
// Single-port byte-lane RAM with an optional zero sweep after reset, per-byte write
// strobes, and a 1- or 2-cycle registered read that answers every request with a ready pulse.
module memory_bytelane #(
    parameter int    DATA_WIDTH     = 32,
    parameter int    DATA_SIZE      = 1024,
    parameter int    ADDR_WIDTH     = 10,
    parameter string PATH           = "",
    parameter int    READ_LATENCY   = 1,
    parameter int    CLEAR_ON_RESET = 0,
    parameter int    RDW_MODE       = 0
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      enable,
    input  logic                      write,
    input  logic [DATA_WIDTH/8-1:0]   byte_en,
    input  logic [ADDR_WIDTH-1:0]     addr_in,
    input  logic [DATA_WIDTH-1:0]     data_in,
    output logic                      ready,
    output logic [DATA_WIDTH-1:0]     r_data_out,
    output logic                      busy,
    output logic                      err
);
    localparam int NB    = DATA_WIDTH / 8;
    localparam int IDX_W = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;
    localparam logic [ADDR_WIDTH:0] SIZE_L   = (ADDR_WIDTH + 1)'(DATA_SIZE);
    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(DATA_SIZE - 1);

    typedef enum logic {RUN, CLEAR} state_t;

    logic [DATA_WIDTH-1:0] mem [DATA_SIZE];

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      clear_addr_q, clear_addr_d;
    logic                  v1_q, v1_d;
    logic                  e1_q, e1_d;
    logic [DATA_WIDTH-1:0] d1_q, d1_d;

    logic                  accept;
    logic                  in_range;
    logic [IDX_W-1:0]      idx;
    logic [IDX_W-1:0]      mem_idx;
    logic [NB-1:0]         mem_be;
    logic [DATA_WIDTH-1:0] mask;
    logic [DATA_WIDTH-1:0] old_word;
    logic [DATA_WIDTH-1:0] new_word;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] mem_wdata;

    // Power-up image: all zeros.
    initial begin
        for (int i = 0; i < DATA_SIZE; i++) mem[i[IDX_W-1:0]] = '0;
    end

    assign busy = (state_q == CLEAR);

    always_comb begin
        in_range = ({1'b0, addr_in} < SIZE_L);
        idx      = addr_in[IDX_W-1:0];
        accept   = enable && (state_q == RUN);
        for (int k = 0; k < NB; k++) mask[8*k +: 8] = {8{byte_en[k]}};
        old_word = in_range ? mem[idx] : '0;
        new_word = (old_word & ~mask) | (data_in & mask);
        if (!in_range)
            rd_word = '0;
        else if (write && (RDW_MODE != 0))
            rd_word = new_word;
        else
            rd_word = old_word;
    end

    always_comb begin
        state_d      = state_q;
        clear_addr_d = clear_addr_q;
        mem_be       = '0;
        mem_idx      = idx;
        mem_wdata    = data_in;
        if (state_q == CLEAR) begin
            mem_be       = '1;
            mem_idx      = clear_addr_q;
            mem_wdata    = '0;
            clear_addr_d = clear_addr_q + 1'b1;
            if (clear_addr_q == LAST_IDX) state_d = RUN;
        end else if (accept && write && in_range) begin
            mem_be = byte_en;
        end
        v1_d = accept;
        e1_d = accept && !in_range;
        d1_d = accept ? rd_word : d1_q;
    end

    // Lane-wise writes keep the array in a byte-enable block RAM shape.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            for (int k = 0; k < NB; k++)
                if (mem_be[k]) mem[mem_idx][8*k +: 8] <= mem_wdata[8*k +: 8];
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q      <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
            clear_addr_q <= '0;
            v1_q         <= 1'b0;
            e1_q         <= 1'b0;
            d1_q         <= '0;
        end else begin
            state_q      <= state_d;
            clear_addr_q <= clear_addr_d;
            v1_q         <= v1_d;
            e1_q         <= e1_d;
            d1_q         <= d1_d;
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic                  v2_q, e2_q;
            logic [DATA_WIDTH-1:0] d2_q, d2_d;

            always_comb d2_d = v1_q ? d1_q : d2_q;

            always_ff @(posedge clk_in) begin
                if (rst_in) begin
                    v2_q <= 1'b0;
                    e2_q <= 1'b0;
                    d2_q <= '0;
                end else begin
                    v2_q <= v1_q;
                    e2_q <= e1_q;
                    d2_q <= d2_d;
                end
            end

            assign ready      = v2_q;
            assign err        = e2_q;
            assign r_data_out = d2_q;
        end else begin : g_lat1
            assign ready      = v1_q;
            assign err        = e1_q;
            assign r_data_out = d1_q;
        end
    endgenerate
endmodule

// File: tb/tb_memory_bytelane.sv
// Bench for memory_bytelane: two configurations (latency 1 / old-word return / 1000 words,
// and latency 2 / merged return / clear sweep / 16 words) checked against a timed expected queue.
module tb_memory_bytelane;
    localparam int A_LAT  = 1;
    localparam int B_LAT  = 2;
    localparam int B_SIZE = 16;

    typedef struct {
        logic        wr;
        logic [9:0]  addr;
        logic [3:0]  be;
        logic [31:0] din;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    typedef struct {
        int          due;
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    logic        a_rst, a_en, a_wr, a_ready, a_busy, a_err;
    logic [3:0]  a_be;
    logic [9:0]  a_addr;
    logic [31:0] a_din, a_dout;
    logic        b_rst, b_en, b_wr, b_ready, b_busy, b_err;
    logic [3:0]  b_be;
    logic [9:0]  b_addr;
    logic [31:0] b_din, b_dout;

    exp_t        a_q[$];
    exp_t        b_q[$];
    exp_t        a_e, b_e;
    logic [31:0] a_last = '0;
    logic [31:0] b_last = '0;
    bit          a_on = 1'b0;
    bit          b_on = 1'b0;
    int          b_busy_from = 0;
    int          b_busy_to = 0;
    vec_t        tbl [17];

    memory_bytelane #(
        .DATA_WIDTH(32), .DATA_SIZE(1000), .ADDR_WIDTH(10), .PATH(""),
        .READ_LATENCY(A_LAT), .CLEAR_ON_RESET(0), .RDW_MODE(0)
    ) dut_a (
        .clk_in(clk), .rst_in(a_rst), .enable(a_en), .write(a_wr), .byte_en(a_be),
        .addr_in(a_addr), .data_in(a_din), .ready(a_ready), .r_data_out(a_dout),
        .busy(a_busy), .err(a_err)
    );

    memory_bytelane #(
        .DATA_WIDTH(32), .DATA_SIZE(B_SIZE), .ADDR_WIDTH(10), .PATH(""),
        .READ_LATENCY(B_LAT), .CLEAR_ON_RESET(1), .RDW_MODE(1)
    ) dut_b (
        .clk_in(clk), .rst_in(b_rst), .enable(b_en), .write(b_wr), .byte_en(b_be),
        .addr_in(b_addr), .data_in(b_din), .ready(b_ready), .r_data_out(b_dout),
        .busy(b_busy), .err(b_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Scoreboard for configuration A: outputs sampled on the falling edge.
    always @(negedge clk) begin
        if (a_on) begin
            if (a_ready) begin
                if (a_q.size() == 0) begin
                    check("a_spurious_ready", 32'(a_ready), 0);
                end else begin
                    a_e = a_q.pop_front();
                    check("a_ready_time", cyc, a_e.due);
                    check("a_data", a_dout, a_e.data);
                    check("a_err", 32'(a_err), 32'(a_e.err));
                    a_last = a_e.data;
                end
            end else begin
                if (a_q.size() != 0 && a_q[0].due <= cyc) begin
                    check("a_missing_ready", 32'(a_ready), 1);
                    void'(a_q.pop_front());
                end
                check("a_hold", a_dout, a_last);
                check("a_err_idle", 32'(a_err), 0);
            end
            check("a_busy", 32'(a_busy), 0);
        end
    end

    always @(negedge clk) begin
        if (b_on) begin
            if (b_ready) begin
                if (b_q.size() == 0) begin
                    check("b_spurious_ready", 32'(b_ready), 0);
                end else begin
                    b_e = b_q.pop_front();
                    check("b_ready_time", cyc, b_e.due);
                    check("b_data", b_dout, b_e.data);
                    check("b_err", 32'(b_err), 32'(b_e.err));
                    b_last = b_e.data;
                end
            end else begin
                if (b_q.size() != 0 && b_q[0].due <= cyc) begin
                    check("b_missing_ready", 32'(b_ready), 1);
                    void'(b_q.pop_front());
                end
                check("b_hold", b_dout, b_last);
                check("b_err_idle", 32'(b_err), 0);
            end
            check("b_busy", 32'(b_busy), 32'(cyc >= b_busy_from && cyc < b_busy_to));
        end
    end

    task automatic drive(input bit sel, input logic en, input logic wr, input logic [9:0] addr,
                         input logic [3:0] be, input logic [31:0] din);
        @(negedge clk);
        #1;
        if (!sel) begin
            a_en = en; a_wr = wr; a_addr = addr; a_be = be; a_din = din;
        end else begin
            b_en = en; b_wr = wr; b_addr = addr; b_be = be; b_din = din;
        end
    endtask

    task automatic idle(input bit sel, input int n);
        for (int i = 0; i < n; i++) drive(sel, 1'b0, 1'b0, 10'd0, 4'h0, 32'h0);
    endtask

    task automatic req(input bit sel, input logic wr, input logic [9:0] addr, input logic [3:0] be,
                       input logic [31:0] din, input logic [31:0] exp_data, input logic exp_err);
        exp_t e;
        drive(sel, 1'b1, wr, addr, be, din);
        e.due  = cyc + (sel ? B_LAT : A_LAT);
        e.data = exp_data;
        e.err  = exp_err;
        if (sel) b_q.push_back(e);
        else     a_q.push_back(e);
    endtask

    // One-cycle reset with enable held high through it; in-flight results are dropped.
    task automatic rst_pulse(input bit sel);
        @(negedge clk);
        #1;
        if (sel) begin
            b_rst = 1'b1; b_en = 1'b1; b_wr = 1'b0;
            b_q.delete(); b_last = '0;
            b_busy_from = cyc + 1; b_busy_to = cyc + 1 + B_SIZE;
        end else begin
            a_rst = 1'b1; a_en = 1'b1; a_wr = 1'b0;
            a_q.delete(); a_last = '0;
        end
        @(negedge clk);
        #1;
        if (sel) begin b_rst = 1'b0; b_en = 1'b0; end
        else     begin a_rst = 1'b0; a_en = 1'b0; end
    endtask

    task automatic wait_b_idle();
        int n = 0;
        while (b_busy === 1'b1 && n < 64) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("b_busy_release", 32'(b_busy), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = '{1'b1, 10'd5,    4'hF,    32'h11223344, 32'h00000000, 1'b0};
        tbl[1]  = '{1'b1, 10'd5,    4'b0101, 32'hAABBCCDD, 32'h11223344, 1'b0};
        tbl[2]  = '{1'b0, 10'd5,    4'hF,    32'h00000000, 32'h11BB33DD, 1'b0};
        tbl[3]  = '{1'b1, 10'd7,    4'hF,    32'h00000001, 32'h00000000, 1'b0};
        tbl[4]  = '{1'b1, 10'd7,    4'hF,    32'h000000FF, 32'h00000001, 1'b0};
        tbl[5]  = '{1'b0, 10'd7,    4'hF,    32'h00000000, 32'h000000FF, 1'b0};
        tbl[6]  = '{1'b1, 10'd999,  4'hF,    32'h12345678, 32'h00000000, 1'b0};
        tbl[7]  = '{1'b1, 10'd1000, 4'hF,    32'h00000005, 32'h00000000, 1'b1};
        tbl[8]  = '{1'b0, 10'd1000, 4'hF,    32'h00000000, 32'h00000000, 1'b1};
        tbl[9]  = '{1'b0, 10'd999,  4'hF,    32'h00000000, 32'h12345678, 1'b0};
        tbl[10] = '{1'b1, 10'd9,    4'h0,    32'hCAFEF00D, 32'h00000000, 1'b0};
        tbl[11] = '{1'b0, 10'd9,    4'hF,    32'h00000000, 32'h00000000, 1'b0};
        tbl[12] = '{1'b1, 10'd1023, 4'hF,    32'hFFFFFFFF, 32'h00000000, 1'b1};
        tbl[13] = '{1'b1, 10'd10,   4'b1010, 32'h55667788, 32'h00000000, 1'b0};
        tbl[14] = '{1'b0, 10'd10,   4'hF,    32'h00000000, 32'h55007700, 1'b0};
        tbl[15] = '{1'b1, 10'd10,   4'b0001, 32'h01020304, 32'h55007700, 1'b0};
        tbl[16] = '{1'b0, 10'd10,   4'hF,    32'h00000000, 32'h55007704, 1'b0};

        a_rst = 1'b1; a_en = 1'b0; a_wr = 1'b0; a_be = '0; a_addr = '0; a_din = '0;
        b_rst = 1'b1; b_en = 1'b0; b_wr = 1'b0; b_be = '0; b_addr = '0; b_din = '0;
        @(negedge clk);
        #1;
        b_busy_from = cyc + 1;
        b_busy_to   = cyc + 1 + B_SIZE;
        a_on = 1'b1;
        b_on = 1'b1;
        @(negedge clk);
        #1;
        a_rst = 1'b0;
        b_rst = 1'b0;

        // Configuration A: back-to-back table, then sparse random reads of untouched words.
        for (int i = 0; i < 17; i++)
            req(1'b0, tbl[i].wr, tbl[i].addr, tbl[i].be, tbl[i].din, tbl[i].exp_data, tbl[i].exp_err);
        idle(1'b0, 2);
        for (int i = 0; i < 8; i++) begin
            req(1'b0, 1'b0, 10'($urandom_range(100, 900)), 4'hF, $urandom, 32'h0, 1'b0);
            idle(1'b0, $urandom_range(0, 2));
        end
        rst_pulse(1'b0);
        idle(1'b0, 1);
        req(1'b0, 1'b0, 10'd5, 4'hF, 32'h0, 32'h11BB33DD, 1'b0);
        req(1'b0, 1'b0, 10'd10, 4'hF, 32'h0, 32'h55007704, 1'b0);
        idle(1'b0, 3);

        // Configuration B: initial sweep, pipelined writes/reads at latency 2, merged returns.
        wait_b_idle();
        for (int i = 0; i < 4; i++) req(1'b1, 1'b1, 10'(i), 4'hF, 32'hA0 + i, 32'hA0 + i, 1'b0);
        for (int i = 0; i < 4; i++) req(1'b1, 1'b0, 10'(i), 4'hF, 32'h0, 32'hA0 + i, 1'b0);
        req(1'b1, 1'b1, 10'd7, 4'hF,    32'h00000001, 32'h00000001, 1'b0);
        req(1'b1, 1'b1, 10'd7, 4'hF,    32'h000000FF, 32'h000000FF, 1'b0);
        req(1'b1, 1'b1, 10'd7, 4'b0010, 32'h0000AB00, 32'h0000ABFF, 1'b0);
        req(1'b1, 1'b1, 10'd7, 4'h0,    32'h12345678, 32'h0000ABFF, 1'b0);
        req(1'b1, 1'b0, 10'd7, 4'hF,    32'h0,        32'h0000ABFF, 1'b0);
        req(1'b1, 1'b0, 10'd20, 4'hF,   32'h0,        32'h0,        1'b1);
        req(1'b1, 1'b1, 10'd16, 4'hF,   32'h5,        32'h0,        1'b1);
        req(1'b1, 1'b0, 10'd0, 4'hF,    32'h0,        32'hA0,       1'b0);
        idle(1'b1, 3);

        // Sweep clears contents on reset.
        req(1'b1, 1'b1, 10'd3, 4'hF, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
        idle(1'b1, 1);
        req(1'b1, 1'b0, 10'd3, 4'hF, 32'h0, 32'hDEADBEEF, 1'b0);
        idle(1'b1, 3);
        rst_pulse(1'b1);
        wait_b_idle();
        req(1'b1, 1'b0, 10'd3, 4'hF, 32'h0, 32'h0, 1'b0);
        req(1'b1, 1'b0, 10'd0, 4'hF, 32'h0, 32'h0, 1'b0);
        idle(1'b1, 3);

        // Reset right behind a read, then requests during the sweep: none may complete.
        req(1'b1, 1'b0, 10'd1, 4'hF, 32'h0, 32'h0, 1'b0);
        rst_pulse(1'b1);
        drive(1'b1, 1'b1, 1'b1, 10'd2, 4'hF, 32'h00000077);
        drive(1'b1, 1'b1, 1'b0, 10'd2, 4'hF, 32'h0);
        drive(1'b1, 1'b1, 1'b1, 10'd2, 4'hF, 32'h00000077);
        idle(1'b1, 1);
        wait_b_idle();
        req(1'b1, 1'b0, 10'd2, 4'hF, 32'h0,        32'h0,        1'b0);
        req(1'b1, 1'b1, 10'd2, 4'hF, 32'h00000077, 32'h00000077, 1'b0);
        req(1'b1, 1'b0, 10'd2, 4'hF, 32'h0,        32'h00000077, 1'b0);
        idle(1'b1, 4);
        idle(1'b0, 2);

        check("a_drain", 32'(a_q.size()), 0);
        check("b_drain", 32'(b_q.size()), 0);
        a_on = 1'b0;
        b_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
